// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-ported, fixed-latency unified memory
// between the MIPS core's instruction-fetch port and its data port.
// One access is outstanding at a time. Ties are broken round robin.
module mips_mem_arbiter #(
    parameter int LATENCY   = 2,    // cycles from m_en to m_rdata valid (1..15)
    parameter bit DATA_PRIO = 1'b1  // 1: data wins the first tie after reset
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ready,
    output logic        i_valid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    // Counter value loaded on leaving ISSUE so that WAIT lasts LATENCY-1 cycles.
    localparam logic [3:0] WAIT_LAST = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        last_data;   // most recent accept went to the data port
    logic        own_data;    // current access belongs to the data port
    logic        own_we;      // current access is a write
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] i_rdata_q;
    logic [31:0] d_rdata_q;
    logic        can_accept;
    logic        grant_i;
    logic        grant_d;
    logic        accept;
    logic        resp;

    // Accept decision: only in IDLE/RESP, round robin when both ports request.
    always_comb begin
        can_accept = reset && (state == IDLE || state == RESP);
        grant_d    = can_accept && d_req && (!i_req || !last_data);
        grant_i    = can_accept && i_req && (!d_req || last_data);
        accept     = grant_i || grant_d;
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic for the issue/wait/response sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   state_next = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (wait_cnt == 4'd0) state_next = RESP;
            RESP:    state_next = accept ? ISSUE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs; everything is forced low while reset is asserted so a
    // mid-access reset never produces a strobe or a valid pulse.
    always_comb begin
        resp    = reset && (state == RESP);
        i_ready = grant_i;
        d_ready = grant_d;
        m_en    = reset && (state == ISSUE);
        m_we    = m_en && own_we;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        busy    = reset && (state != IDLE);
        i_valid = resp && !own_data;
        d_valid = resp && own_data;
        i_rdata = i_valid ? m_rdata : i_rdata_q;
        d_rdata = d_valid ? (own_we ? 32'd0 : m_rdata) : d_rdata_q;
    end

    // Request capture, latency counter and held read data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt  <= 4'd0;
            last_data <= ~DATA_PRIO;
            own_data  <= 1'b0;
            own_we    <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
        end else begin
            if (accept) begin
                own_data  <= grant_d;
                own_we    <= grant_d && d_we;
                addr_q    <= grant_d ? d_addr : i_addr;
                wdata_q   <= grant_d ? d_wdata : 32'd0;
                last_data <= grant_d;
            end
            if (state == ISSUE)
                wait_cnt <= WAIT_LAST;
            else if (state == WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (i_valid) i_rdata_q <= m_rdata;
            if (d_valid) d_rdata_q <= own_we ? 32'd0 : m_rdata;
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: directed and random stimulus against a transaction-level
// reference model of the arbiter plus a fixed-latency memory model.
module tb_mips_mem_arbiter;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic        i_ready, i_valid, d_ready, d_valid;
    logic [31:0] i_rdata, d_rdata;
    logic        m_en, m_we, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    mips_mem_arbiter #(.LATENCY(LAT), .DATA_PRIO(1'b1)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [7:0] idx);
        return 32'h5A00_0000 ^ ({24'd0, idx} * 32'h0001_0203);
    endfunction

    // Memory environment: 256 words, read data appears LAT cycles after m_en.
    logic [31:0] env_mem [256];
    logic [255:0] written = '0;
    logic [31:0] rd_pipe [LAT];
    assign m_rdata = rd_pipe[LAT-1];

    // Memory model: write on strobe, push read data (or noise) into the latency pipe.
    always @(posedge clk) begin
        rd_pipe[0] <= (m_en && !m_we) ?
                      (written[m_addr[9:2]] ? env_mem[m_addr[9:2]] : pat(m_addr[9:2])) :
                      $urandom;
        for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
        if (m_en && m_we) begin
            env_mem[m_addr[9:2]] <= m_wdata;
            written[m_addr[9:2]] <= 1'b1;
        end
    end

    // Reference model state (transaction level: cycle numbers of events).
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          free_at = 0;
    int          issue_at = -1;
    int          resp_at = -1;
    logic        last_d = 1'b0;
    logic        own_d = 1'b0, own_we = 1'b0;
    logic [31:0] own_addr = 32'd0, own_wdata = 32'd0;
    logic [31:0] cur_addr = 32'd0, exp_rd = 32'd0;
    logic [31:0] held_i = 32'd0, held_d = 32'd0;
    logic        prev_rst_low = 1'b0;
    logic        ei, ed;
    logic [31:0] ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cycle();
        ei = 1'b0;
        ed = 1'b0;
        if (!reset) begin
            chk("rst_i_ready", {31'd0, i_ready}, 32'd0);
            chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
            chk("rst_m_en",    {31'd0, m_en},    32'd0);
            chk("rst_i_valid", {31'd0, i_valid}, 32'd0);
            chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
            chk("rst_busy",    {31'd0, busy},    32'd0);
            if (prev_rst_low) begin
                chk("rst_m_we",    {31'd0, m_we}, 32'd0);
                chk("rst_m_addr",  m_addr,  32'd0);
                chk("rst_m_wdata", m_wdata, 32'd0);
                chk("rst_i_rdata", i_rdata, 32'd0);
                chk("rst_d_rdata", d_rdata, 32'd0);
            end
        end else begin
            if (cyc >= free_at) begin
                ed = d_req && (!i_req || !last_d);
                ei = i_req && (!d_req || last_d);
            end
            chk("i_ready", {31'd0, i_ready}, {31'd0, ei});
            chk("d_ready", {31'd0, d_ready}, {31'd0, ed});
            if (cyc == issue_at) begin
                cur_addr = own_addr;
                if (own_we) ref_mem[own_addr[9:2]] = own_wdata;
                else        exp_rd = ref_mem[own_addr[9:2]];
                if (own_we) chk("m_wdata", m_wdata, own_wdata);
            end
            chk("m_en",   {31'd0, m_en}, {31'd0, cyc == issue_at});
            chk("m_we",   {31'd0, m_we}, {31'd0, (cyc == issue_at) && own_we});
            chk("m_addr", m_addr, cur_addr);
            chk("busy",   {31'd0, busy}, {31'd0, (cyc >= issue_at) && (cyc <= resp_at)});
            if (cyc == resp_at) begin
                if (own_d) held_d = own_we ? 32'd0 : exp_rd;
                else       held_i = exp_rd;
            end
            chk("i_valid", {31'd0, i_valid}, {31'd0, (cyc == resp_at) && !own_d});
            chk("d_valid", {31'd0, d_valid}, {31'd0, (cyc == resp_at) && own_d});
            chk("i_rdata", i_rdata, held_i);
            chk("d_rdata", d_rdata, held_d);
        end
    endtask

    task automatic update_model();
        if (!reset) begin
            free_at  = cyc + 1;
            issue_at = -1;
            resp_at  = -1;
            last_d   = 1'b0;
            cur_addr = 32'd0;
            held_i   = 32'd0;
            held_d   = 32'd0;
        end else if (ei || ed) begin
            own_d     = ed;
            own_we    = ed && d_we;
            own_addr  = ed ? d_addr : i_addr;
            own_wdata = ed ? d_wdata : 32'd0;
            issue_at  = cyc + 1;
            resp_at   = cyc + 1 + LAT;
            free_at   = resp_at;
            last_d    = ed;
        end
        prev_rst_low = !reset;
        cyc++;
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_cycle();
            @(posedge clk);
            update_model();
            #1;
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        i_req = 1'b1; i_addr = a;
        tick(1);
        i_req = 1'b0;
        tick(LAT + 1);
    endtask

    task automatic data_acc(input logic we, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        tick(1);
        d_req = 1'b0; d_we = 1'b0;
        tick(LAT + 1);
    endtask

    initial begin
        for (int k = 0; k < 256; k++) ref_mem[k] = pat(8'(k));
        // Reset held two cycles with both ports requesting.
        reset = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        i_addr = 32'h0000_0200; d_addr = 32'h0000_0204; d_wdata = 32'd0;
        tick(2);
        reset = 1'b1;
        tick(1);
        i_req = 1'b0; d_req = 1'b0;
        tick(LAT + 2);
        // Fetch only.
        fetch(32'h0000_0040);
        // Data write, then read it back through the fetch path.
        data_acc(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        fetch(32'h0000_0100);
        data_acc(1'b0, 32'h0000_0100, 32'h1234_5678);
        // Both ports held for four accepts.
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_00C0; d_addr = 32'h0000_0080;
        tick(4 * (LAT + 1));
        i_req = 1'b0; d_req = 1'b0;
        tick(LAT + 1);
        // Reset in the WAIT cycle of a read.
        d_req = 1'b1; d_addr = 32'h0000_0044;
        tick(1);
        d_req = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(LAT + 1);
        fetch(32'h0000_0048);
        // Fetch request pulsed while an access is waiting.
        i_req = 1'b1; i_addr = 32'h0000_0010;
        tick(1);
        i_req = 1'b0;
        tick(1);
        i_req = 1'b1; i_addr = 32'h0000_0014;
        tick(1);
        i_req = 1'b0;
        tick(LAT + 1);
        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 40) != 0);
            i_req   = $urandom_range(0, 1) == 1;
            d_req   = $urandom_range(0, 1) == 1;
            d_we    = $urandom_range(0, 1) == 1;
            i_addr  = {22'd0, 8'($urandom), 2'b00};
            d_addr  = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            d_wdata = $urandom;
            tick(1);
        end
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;
        tick(LAT + 2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
